// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types, select encodings and helpers for the mem_arb3 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 3;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // An out-of-range index maps to SEL_A, so the select never shows 2'b11.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_A;
      2'd1:    return SEL_B;
      2'd2:    return SEL_C;
      default: return SEL_A;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ============================================================================
// Module   : rr_pick3
// Brief    : Combinational 3-way round-robin pick; search order ptr, ptr+1, ptr+2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick3
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic             found_o,
  output logic [1:0]       idx_o
);

  logic [2:0] w_cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    w_cand  = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, ptr_i} + 3'(k);
      if (w_cand >= 3'(N_REQ)) w_cand = w_cand - 3'(N_REQ);
      if (!found_o && req_i[w_cand[1:0]]) begin
        found_o = 1'b1;
        idx_o   = w_cand[1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb3.sv
// ============================================================================
// Module   : mem_arb3
// Brief    : Burst-holding round-robin arbiter for one shared 32-bit bus port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb3
  import arb_pkg::*;
#(
  parameter int BURST_MAX = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  input  logic             slv_ready_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       se_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam logic [7:0] C_BURST_MAX = 8'(BURST_MAX);

  arb_state_t       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       se_q, se_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             w_granted, w_own_req, w_beat, w_last_beat, w_cap_beat;
  logic             w_forced, w_release, w_found;
  logic [7:0]       w_cnt_inc;
  logic [1:0]       w_owner_nxt, w_arb_ptr, w_win;
  logic [N_REQ-1:0] w_arb_req;

  assign w_granted   = (state_q == GRANT);
  assign w_own_req   = req_i[owner_q];
  assign w_beat      = w_granted && w_own_req && slv_ready_i;
  assign w_cnt_inc   = cnt_q + 8'd1;
  assign w_last_beat = w_beat && last_i[owner_q];
  assign w_cap_beat  = w_beat && (w_cnt_inc == C_BURST_MAX);
  assign w_forced    = w_cap_beat && !last_i[owner_q];
  assign w_release   = w_granted && (!w_own_req || w_last_beat || w_cap_beat);
  assign w_owner_nxt = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;

  // On release the old owner is searched last; it only competes at all when
  // its burst was cut short by the beat cap and it still has beats to send.
  assign w_arb_ptr = w_granted ? w_owner_nxt : ptr_q;
  assign w_arb_req = (w_granted && !w_forced) ? (req_i & ~gnt_q) : req_i;

  rr_pick3 u_pick (
    .req_i   (w_arb_req),
    .ptr_i   (w_arb_ptr),
    .found_o (w_found),
    .idx_o   (w_win)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    se_d    = se_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d        = GRANT;
          owner_d        = w_win;
          cnt_d          = 8'd0;
          gnt_d          = '0;
          gnt_d[w_win]   = 1'b1;
          se_d           = idx_to_sel(w_win);
        end
      end
      GRANT: begin
        if (w_release) begin
          ptr_d = w_owner_nxt;
          cnt_d = 8'd0;
          if (w_found) begin
            owner_d      = w_win;
            gnt_d        = '0;
            gnt_d[w_win] = 1'b1;
            se_d         = idx_to_sel(w_win);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            se_d    = SEL_A;
          end
        end else if (w_beat) begin
          cnt_d = w_cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      se_q    <= SEL_A;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      se_q    <= se_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign se_o    = se_q;
  assign busy_o  = w_granted;
  assign valid_o = w_granted && w_own_req;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb3.sv
// ============================================================================
// Module   : tb_mem_arb3
// Brief    : Directed plus randomized checks of mem_arb3 against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb3;

  localparam int BMAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] last = 3'b000;
  logic       rdy = 1'b0;
  logic [2:0] gnt;
  logic [1:0] se;
  logic       valid;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: owner (-1 when idle), priority pointer, beats this grant.
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  mem_arb3 #(.BURST_MAX(BMAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .last_i      (last),
    .slv_ready_i (rdy),
    .gnt_o       (gnt),
    .se_o        (se),
    .valid_o     (valid),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One clock: drive inputs, compare DUT against model, then advance model.
  task automatic step(input logic r_rst, input logic [2:0] r_req, input logic [2:0] r_last,
                      input logic r_rdy);
    int o;
    logic [2:0] cands;
    bit beat, done_last, capped;
    @(negedge clk);
    rst = r_rst; req = r_req; last = r_last; rdy = r_rdy;
    #1;
    chk("gnt", 8'(gnt), (m_owner < 0) ? 8'd0 : 8'(1 << m_owner));
    chk("se", 8'(se), (m_owner < 0) ? 8'd0 : 8'(m_owner));
    chk("busy", 8'(busy), 8'(m_owner >= 0));
    chk("valid", 8'(valid), 8'((m_owner >= 0) && r_req[m_owner]));
    chk("se_legal", 8'(se != 2'b11), 8'd1);
    chk("onehot0", 8'($onehot0(gnt)), 8'd1);
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(r_req, m_ptr);
      m_cnt = 0;
    end else begin
      o = m_owner;
      beat = r_req[o] && r_rdy;
      done_last = beat && r_last[o];
      capped = beat && (m_cnt + 1 == BMAX);
      if (!r_req[o] || done_last || capped) begin
        m_ptr = (o + 1) % 3;
        cands = r_req;
        if (!(capped && !done_last)) cands[o] = 1'b0;
        m_owner = pick(cands, m_ptr);
        m_cnt = 0;
      end else if (beat) begin
        m_cnt++;
      end
    end
  endtask

  logic [2:0] exp_order [6];
  int act [3];
  int rem [3];

  initial begin
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state
    step(1, 3'b000, 3'b000, 0);
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b000, 3'b000, 1);
    chk("rst_gnt", 8'(gnt), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);

    // Single-beat transfer from requester 1
    step(0, 3'b010, 3'b010, 1);
    step(0, 3'b010, 3'b010, 1);
    chk("t1_gnt", 8'(gnt), 8'h02);
    chk("t1_se", 8'(se), 8'h01);
    chk("t1_valid", 8'(valid), 8'd1);
    step(0, 3'b000, 3'b000, 1);
    chk("t1_idle_gnt", 8'(gnt), 8'd0);
    chk("t1_idle_busy", 8'(busy), 8'd0);

    // All requesting, every beat last: strict rotation with no idle gap
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b111, 3'b111, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, 3'b111, 3'b111, 1);
      chk("t2_order", 8'(gnt), 8'(exp_order[k]));
    end

    // Beat cap on requester 2, then handover to 0, then regrant with fresh count
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b100, 3'b000, 1);
    for (int k = 0; k < BMAX; k++) step(0, 3'b101, 3'b000, 1);
    step(0, 3'b101, 3'b000, 1);
    chk("t3_handover", 8'(gnt), 8'h01);
    step(0, 3'b100, 3'b000, 1);
    for (int k = 0; k < BMAX; k++) step(0, 3'b100, 3'b000, 1);
    chk("t3_regrant", 8'(gnt), 8'h04);
    for (int k = 0; k < BMAX - 1; k++) step(0, 3'b100, 3'b000, 1);
    step(0, 3'b101, 3'b000, 1);
    step(0, 3'b101, 3'b000, 1);
    chk("t3_recount", 8'(gnt), 8'h01);

    // Ready stall mid-burst holds grant and count
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b010, 3'b000, 1);
    step(0, 3'b010, 3'b000, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 3'b010, 3'b000, 0);
      chk("t4_stall_valid", 8'(valid), 8'd1);
    end
    step(0, 3'b010, 3'b000, 1);
    step(0, 3'b010, 3'b000, 1);
    chk("t4_held", 8'(gnt), 8'h02);
    step(0, 3'b110, 3'b000, 1);
    step(0, 3'b100, 3'b000, 1);
    chk("t4_cap", 8'(gnt), 8'h04);

    // Owner abandons before last
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b010, 3'b000, 1);
    step(0, 3'b110, 3'b000, 1);
    step(0, 3'b100, 3'b000, 0);
    step(0, 3'b100, 3'b000, 0);
    chk("t5_gnt", 8'(gnt), 8'h04);
    chk("t5_se", 8'(se), 8'h02);

    // Reset mid-burst
    step(1, 3'b000, 3'b000, 0);
    step(0, 3'b100, 3'b000, 1);
    step(0, 3'b100, 3'b000, 1);
    step(1, 3'b111, 3'b000, 1);
    step(0, 3'b111, 3'b000, 1);
    chk("t6_gnt", 8'(gnt), 8'd0);
    chk("t6_busy", 8'(busy), 8'd0);
    step(0, 3'b111, 3'b000, 1);
    chk("t6_first", 8'(gnt), 8'h01);

    // Randomized protocol-respecting traffic
    step(1, 3'b000, 3'b000, 0);
    for (int r = 0; r < 3; r++) begin act[r] = 0; rem[r] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0] rq, ls;
      logic rd;
      int po;
      for (int r = 0; r < 3; r++) begin
        if (act[r] == 0 && $urandom_range(0, 3) == 0) begin
          act[r] = 1;
          rem[r] = int'($urandom_range(1, 7));
        end else if (act[r] != 0 && $urandom_range(0, 24) == 0) begin
          act[r] = 0;
        end
        rq[r] = (act[r] != 0);
        ls[r] = (act[r] != 0) && (rem[r] == 1);
      end
      rd = ($urandom_range(0, 3) != 0);
      po = m_owner;
      step(0, rq, ls, rd);
      if (po >= 0 && rq[po] && rd) begin
        rem[po]--;
        if (ls[po]) act[po] = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arb3.md
Name: mem_arb3

Overview:
- Round-robin arbiter that shares one 32-bit memory/bus port between three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = crypto/DMA engine.
- Drives the 2-bit select of the 3:1 32-bit datapath muxes that steer address, write data and control onto the shared port. Encoding: 00 = requester 0, 01 = requester 1, 10 = requester 2.
- Holds each grant for a whole transaction (a burst of beats), up to a fairness limit.

Parameters:
- BURST_MAX, 8, maximum beats per grant before the grant is force-released (range 1..255).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  3  per-requester request; held high until the transaction's last beat is accepted.
- last_i  in  3  per-requester flag marking the final beat of the current transaction.
- slv_ready_i  in  1  shared port accepts the current beat this cycle.
- gnt_o  out  3  one-hot grant, registered.
- se_o  out  2  mux select, registered; encoding 00/01/10 as above; 11 is never driven.
- valid_o  out  1  beat presented to the shared port (req_i[owner] while granted).
- busy_o  out  1  a grant is active.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - gnt_o = 000, se_o = 00, busy_o = 0, valid_o = 0.
  - Priority pointer = 0, beat counter = 0, state = IDLE.
  - Reset mid-burst drops the grant immediately; there is no completion handshake.
- States:
  - IDLE: no owner. valid_o = 0.
  - GRANT: owner index held in a register.
- Arbitration: round-robin starting at the pointer. Search order is ptr, ptr+1, ptr+2 (mod 3); the first requester asserting req_i wins.
- IDLE -> GRANT:
  - If any req_i is high at edge N, gnt_o, se_o and busy_o reflect the winner from edge N+1 (one-cycle grant latency).
  - Beat counter clears.
- GRANT behaviour:
  - valid_o = req_i[owner] (combinational).
  - A beat is accepted in a cycle where req_i[owner] && slv_ready_i; the counter increments on each accepted beat.
- Release occurs at the edge ending a cycle in which any of these holds:
  - (a) an accepted beat has last_i[owner] = 1;
  - (b) an accepted beat brings the count to BURST_MAX (forced release, even without last);
  - (c) req_i[owner] = 0 (abandon; no beat is counted).
- On release:
  - Pointer = owner+1 mod 3.
  - Re-arbitration happens in the same cycle using the new pointer, so the released owner has lowest priority.
  - If another requester is waiting, the grant switches directly with no IDLE bubble.
  - Otherwise, if the old owner still requests (the forced-release case), it is regranted; else the block goes to IDLE with gnt_o = 000 and se_o = 00.
- slv_ready_i while no beat is presented is ignored.
- last_i and req_i of non-owners are ignored while granted.
- se_o always equals the encoded index of the one-hot gnt_o. In IDLE, se_o = 00 and gnt_o = 000; consumers must qualify with busy_o.
- Invariant: gnt_o is one-hot or zero; se_o never equals 11.

Decomposition:
- Package arb_pkg:
  - N_REQ = 3.
  - SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10.
  - typedef enum {IDLE, GRANT} arb_state_t.
  - Helper function idx_to_sel.
- Sub-module rr_pick3: purely combinational.
  - Inputs: 3-bit request vector, 2-bit pointer.
  - Outputs: found flag, 2-bit winner index.
  - Used for both the IDLE and the release-time arbitration.

Test Plan:
1. Reset, then req_i = 010, last_i = 010, slv_ready_i = 1:
   - gnt_o = 010 and se_o = 01 one cycle later.
   - valid_o = 1 for 1 beat.
   - Then IDLE: gnt_o = 000, busy_o = 0.
2. req_i = 111 held, every beat with last, slv_ready_i = 1:
   - Grant order 0, 1, 2, 0, 1, 2.
   - se_o sequence 00, 01, 10, 00, ...
   - No idle cycles between grants.
3. BURST_MAX = 4, requester 2 with last never set, requester 0 also requesting:
   - Release after exactly 4 accepted beats.
   - Grant moves to 0 on the next cycle.
   - With requester 0 idle instead, requester 2 is regranted and the counter restarts.
4. slv_ready_i stalls (low for 3 cycles mid-burst):
   - Counter does not advance.
   - Grant is held.
   - valid_o stays 1.
5. Owner 1 drops req_i before last:
   - Grant released at that edge.
   - Pointer moves to 2.
   - Pending requester 2 is granted next cycle.
6. rst_i asserted mid-burst:
   - Next cycle gnt_o = 000, se_o = 00, busy_o = 0.
   - After release, requester 0 wins the first arbitration over pending 1 and 2.
